commit_dests: RTL and testbench



---
 rtl/commit_dests_pkg.sv | 27 ++
 rtl/commit_hint_match.sv | 30 +++
 rtl/commit_dests.sv | 193 +++++++++++++++++++
 tb/tb_commit_dests.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_dests_pkg.sv
// Shared encodings for the commit/writeback sequencer.
//   OPND_DEST_* : destination kind encodings and their one-hot bit indices
//   COMMIT_FAULT_* : bit positions in the sticky fault vector
//   REG_* : register selectors, EAX=0 .. EDI=7
package commit_dests_pkg;

  localparam logic [1:0] OPND_DEST_NONE     = 2'b00;
  localparam logic [1:0] OPND_DEST_REG_1HOT = 2'b01;
  localparam logic [1:0] OPND_DEST_MEM_1HOT = 2'b10;

  localparam int unsigned OPND_DEST_REG = 0;
  localparam int unsigned OPND_DEST_MEM = 1;

  localparam int unsigned COMMIT_FAULT_ILLEGAL = 0;
  localparam int unsigned COMMIT_FAULT_MEM     = 1;
  localparam int unsigned COMMIT_FAULT_HINT    = 2;

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

endpackage

// File: rtl/commit_hint_match.sv
// Combinational match of one memory destination against the two write hints.
// Ports:
//   addr, val      : destination effective address and value
//   hint ports     : latched write/read direction, address and data of each hint
//   used1, used2   : hint already consumed by an earlier destination
//   match1, match2 : the first or second hint explains this destination; the first
//                    hint has priority, so at most one is asserted
module commit_hint_match (
  input  logic [31:0] addr,
  input  logic [31:0] val,
  input  logic        hint1_is_write,
  input  logic [31:0] hint1_address,
  input  logic [31:0] hint1_data,
  input  logic        hint2_is_write,
  input  logic [31:0] hint2_address,
  input  logic [31:0] hint2_data,
  input  logic        used1,
  input  logic        used2,
  output logic        match1,
  output logic        match2
);

  logic cand1, cand2;

  assign cand1  = hint1_is_write && (hint1_address == addr) && (hint1_data == val) && !used1;
  assign cand2  = hint2_is_write && (hint2_address == addr) && (hint2_data == val) && !used2;
  assign match1 = cand1;
  assign match2 = cand2 && !cand1;

endmodule

// File: rtl/commit_dests.sv
// Writeback/commit sequencer. Accepts a bundle of two destination descriptors with
// their result values plus two memory hints, then over fixed cycles issues register
// writes (dest0, then dest1) and checks memory destinations against write hints.
// Completion is offered on done_valid with a sticky fault vector.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready          : bundle handshake
//   destN_kind/sel/val         : destination descriptors and values
//   hintN_is_write/address/data: memory hints
//   rf_we/rf_sel/rf_data       : one-cycle register write strobe
//   done_valid/done_ready      : completion handshake
//   fault                      : [0] illegal kind/sel, [1] unmatched mem, [2] unused hint
// Optional feature: define COMMIT_UNUSED_HINT_CHECK_EN to flag write hints that no
// memory destination consumed.
module commit_dests
  import commit_dests_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  dest0_kind,
  input  logic [31:0] dest0_sel,
  input  logic [31:0] dest0_val,
  input  logic [1:0]  dest1_kind,
  input  logic [31:0] dest1_sel,
  input  logic [31:0] dest1_val,
  input  logic        hint1_is_write,
  input  logic [31:0] hint1_address,
  input  logic [31:0] hint1_data,
  input  logic        hint2_is_write,
  input  logic [31:0] hint2_address,
  input  logic [31:0] hint2_data,
  output logic        rf_we,
  output logic [2:0]  rf_sel,
  output logic [31:0] rf_data,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [2:0]  fault
);

  typedef enum logic [1:0] {StIdle, StWb0, StWb1, StFin} state_e;

  state_e      state_q;
  logic [1:0]  kind0_q, kind1_q;
  logic [31:0] sel0_q, sel1_q, val0_q, val1_q;
  logic        h1_we_q, h2_we_q;
  logic [31:0] h1_addr_q, h1_data_q, h2_addr_q, h2_data_q;
  logic        used1_q, used2_q;

  logic [1:0]  cur_kind;
  logic [31:0] cur_sel, cur_val;
  logic        match1, match2;
  logic        step_we;
  logic [2:0]  step_fault;
  logic        step_used1, step_used2;

  // The write-back stages share one datapath; the state picks which latched dest.
  always_comb begin
    cur_kind = kind0_q;
    cur_sel  = sel0_q;
    cur_val  = val0_q;
    if (state_q == StWb1) begin
      cur_kind = kind1_q;
      cur_sel  = sel1_q;
      cur_val  = val1_q;
    end
  end

  commit_hint_match u_hint_match (
    .addr           (cur_sel),
    .val            (cur_val),
    .hint1_is_write (h1_we_q),
    .hint1_address  (h1_addr_q),
    .hint1_data     (h1_data_q),
    .hint2_is_write (h2_we_q),
    .hint2_address  (h2_addr_q),
    .hint2_data     (h2_data_q),
    .used1          (used1_q),
    .used2          (used2_q),
    .match1         (match1),
    .match2         (match2)
  );

  // Effect of the current write-back stage on write strobe, faults and hint usage.
  always_comb begin
    step_we    = 1'b0;
    step_fault = fault;
    step_used1 = used1_q;
    step_used2 = used2_q;
    if (cur_kind[OPND_DEST_REG] && cur_kind[OPND_DEST_MEM]) begin
      step_fault[COMMIT_FAULT_ILLEGAL] = 1'b1;
    end else if (cur_kind[OPND_DEST_REG]) begin
      if (cur_sel[31:3] == 29'd0) begin
        step_we = 1'b1;
      end else begin
        step_fault[COMMIT_FAULT_ILLEGAL] = 1'b1;
      end
    end else if (cur_kind[OPND_DEST_MEM]) begin
      if (match1) begin
        step_used1 = 1'b1;
      end else if (match2) begin
        step_used2 = 1'b1;
      end else begin
        step_fault[COMMIT_FAULT_MEM] = 1'b1;
      end
    end
`ifdef COMMIT_UNUSED_HINT_CHECK_EN
    // Uses this stage's updated flags so a hint consumed by dest1 counts as used.
    if ((state_q == StWb1) &&
        ((h1_we_q && !step_used1) || (h2_we_q && !step_used2))) begin
      step_fault[COMMIT_FAULT_HINT] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      rf_we      <= 1'b0;
      rf_sel     <= REG_EAX;
      rf_data    <= 32'd0;
      done_valid <= 1'b0;
      fault      <= 3'd0;
      used1_q    <= 1'b0;
      used2_q    <= 1'b0;
      kind0_q    <= OPND_DEST_NONE;
      kind1_q    <= OPND_DEST_NONE;
      sel0_q     <= 32'd0;
      sel1_q     <= 32'd0;
      val0_q     <= 32'd0;
      val1_q     <= 32'd0;
      h1_we_q    <= 1'b0;
      h2_we_q    <= 1'b0;
      h1_addr_q  <= 32'd0;
      h1_data_q  <= 32'd0;
      h2_addr_q  <= 32'd0;
      h2_data_q  <= 32'd0;
    end else begin
      // Write strobe and its payload are single-cycle and zero otherwise.
      rf_we   <= 1'b0;
      rf_sel  <= REG_EAX;
      rf_data <= 32'd0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            kind0_q   <= dest0_kind;
            sel0_q    <= dest0_sel;
            val0_q    <= dest0_val;
            kind1_q   <= dest1_kind;
            sel1_q    <= dest1_sel;
            val1_q    <= dest1_val;
            h1_we_q   <= hint1_is_write;
            h1_addr_q <= hint1_address;
            h1_data_q <= hint1_data;
            h2_we_q   <= hint2_is_write;
            h2_addr_q <= hint2_address;
            h2_data_q <= hint2_data;
            fault     <= 3'd0;
            used1_q   <= 1'b0;
            used2_q   <= 1'b0;
            in_ready  <= 1'b0;
            state_q   <= StWb0;
          end
        end
        StWb0, StWb1: begin
          if (step_we) begin
            rf_we   <= 1'b1;
            rf_sel  <= cur_sel[2:0];
            rf_data <= cur_val;
          end
          fault   <= step_fault;
          used1_q <= step_used1;
          used2_q <= step_used2;
          state_q <= (state_q == StWb0) ? StWb1 : StFin;
        end
        StFin: begin
          // First FIN cycle only raises done_valid, fixing completion at accept + 3.
          if (!done_valid) begin
            done_valid <= 1'b1;
          end else if (done_ready) begin
            done_valid <= 1'b0;
            in_ready   <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_dests.sv
module tb_commit_dests;
  import commit_dests_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  dest0_kind, dest1_kind;
  logic [31:0] dest0_sel, dest0_val, dest1_sel, dest1_val;
  logic        hint1_is_write, hint2_is_write;
  logic [31:0] hint1_address, hint1_data, hint2_address, hint2_data;
  logic        rf_we;
  logic [2:0]  rf_sel;
  logic [31:0] rf_data;
  logic        done_valid;
  logic        done_ready;
  logic [2:0]  fault;

  int tests = 0;
  int fails = 0;

`ifdef COMMIT_UNUSED_HINT_CHECK_EN
  localparam logic [2:0] HINTF = 3'b100;
`else
  localparam logic [2:0] HINTF = 3'b000;
`endif

  commit_dests dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dest0_kind     (dest0_kind),
    .dest0_sel      (dest0_sel),
    .dest0_val      (dest0_val),
    .dest1_kind     (dest1_kind),
    .dest1_sel      (dest1_sel),
    .dest1_val      (dest1_val),
    .hint1_is_write (hint1_is_write),
    .hint1_address  (hint1_address),
    .hint1_data     (hint1_data),
    .hint2_is_write (hint2_is_write),
    .hint2_address  (hint2_address),
    .hint2_data     (hint2_data),
    .rf_we          (rf_we),
    .rf_sel         (rf_sel),
    .rf_data        (rf_data),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic        we0;
    logic [2:0]  sel0;
    logic [31:0] data0;
    logic        we1;
    logic [2:0]  sel1;
    logic [31:0] data1;
    logic [2:0]  fault;
  } res_t;

  // Whole-step outcome from the commit rules: registers written, hints consumed.
  function automatic res_t model_step(
      input logic [1:0] k0, input logic [31:0] s0, input logic [31:0] v0,
      input logic [1:0] k1, input logic [31:0] s1, input logic [31:0] v1,
      input logic hw1, input logic [31:0] ha1, input logic [31:0] hd1,
      input logic hw2, input logic [31:0] ha2, input logic [31:0] hd2);
    res_t r;
    logic [1:0]  kd[2];
    logic [31:0] sd[2], vd[2], ha[2], hd[2];
    logic        hw[2], used[2], found;
    r = '0;
    kd[0] = k0; sd[0] = s0; vd[0] = v0;
    kd[1] = k1; sd[1] = s1; vd[1] = v1;
    hw[0] = hw1; ha[0] = ha1; hd[0] = hd1;
    hw[1] = hw2; ha[1] = ha2; hd[1] = hd2;
    used[0] = 1'b0; used[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (kd[d] == 2'b01) begin
        if (sd[d] < 32'd8) begin
          if (d == 0) begin r.we0 = 1'b1; r.sel0 = sd[d][2:0]; r.data0 = vd[d]; end
          else        begin r.we1 = 1'b1; r.sel1 = sd[d][2:0]; r.data1 = vd[d]; end
        end else begin
          r.fault[0] = 1'b1;
        end
      end else if (kd[d] == 2'b10) begin
        found = 1'b0;
        for (int h = 0; h < 2; h++) begin
          if (!found && hw[h] && !used[h] && ha[h] == sd[d] && hd[h] == vd[d]) begin
            used[h] = 1'b1;
            found   = 1'b1;
          end
        end
        if (!found) r.fault[1] = 1'b1;
      end else if (kd[d] == 2'b11) begin
        r.fault[0] = 1'b1;
      end
    end
`ifdef COMMIT_UNUSED_HINT_CHECK_EN
    for (int h = 0; h < 2; h++) if (hw[h] && !used[h]) r.fault[2] = 1'b1;
`endif
    return r;
  endfunction

  // m_cyc: 0 idle, 1 just accepted, 2 dest0 strobe, 3 dest1 strobe, 4 done offered
  int   m_cyc;
  res_t m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0;
      m_res <= '0;
    end else if (m_cyc == 0) begin
      if (in_valid) begin
        m_res <= model_step(dest0_kind, dest0_sel, dest0_val, dest1_kind, dest1_sel, dest1_val,
                            hint1_is_write, hint1_address, hint1_data,
                            hint2_is_write, hint2_address, hint2_data);
        m_cyc <= 1;
      end
    end else if (m_cyc < 4) begin
      m_cyc <= m_cyc + 1;
    end else if (done_ready) begin
      m_cyc <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        e_we;
    logic [2:0]  e_sel;
    logic [31:0] e_data;
    e_we   = 1'b0;
    e_sel  = 3'd0;
    e_data = 32'd0;
    if (m_cyc == 2 && m_res.we0) begin e_we = 1'b1; e_sel = m_res.sel0; e_data = m_res.data0; end
    if (m_cyc == 3 && m_res.we1) begin e_we = 1'b1; e_sel = m_res.sel1; e_data = m_res.data1; end
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("rf_sel", {29'd0, rf_sel}, {29'd0, e_sel});
    chk("rf_data", rf_data, e_data);
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_cyc == 0});
    chk("done_valid", {31'd0, done_valid}, {31'd0, m_cyc == 4});
    if (m_cyc == 0 || m_cyc == 4) chk("fault", {29'd0, fault}, {29'd0, m_res.fault});
  end

  // Write monitor used for per-step literal checks.
  int          wr_total;
  logic [2:0]  last_sel;
  logic [31:0] last_data;
  always @(negedge clk) begin
    if (rf_we) begin
      wr_total  <= wr_total + 1;
      last_sel  <= rf_sel;
      last_data <= rf_data;
    end
  end

  // ---------------------------------------------------------------- stimulus
  typedef struct {
    logic [1:0]  k0;
    logic [31:0] s0, v0;
    logic [1:0]  k1;
    logic [31:0] s1, v1;
    logic        hw1;
    logic [31:0] ha1, hd1;
    logic        hw2;
    logic [31:0] ha2, hd2;
    logic [2:0]  exp_fault;
    int          exp_nwr;
    int          rdy_dly;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic drive_vec(input vec_t v);
    dest0_kind = v.k0; dest0_sel = v.s0; dest0_val = v.v0;
    dest1_kind = v.k1; dest1_sel = v.s1; dest1_val = v.v1;
    hint1_is_write = v.hw1; hint1_address = v.ha1; hint1_data = v.hd1;
    hint2_is_write = v.hw2; hint2_address = v.ha2; hint2_data = v.hd2;
  endtask

  // Scramble live inputs after accept; the step must use only latched copies.
  task automatic scramble();
    dest0_kind = 2'($urandom); dest0_sel = $urandom; dest0_val = $urandom;
    dest1_kind = 2'($urandom); dest1_sel = $urandom; dest1_val = $urandom;
    hint1_is_write = 1'($urandom); hint1_address = $urandom; hint1_data = $urandom;
    hint2_is_write = 1'($urandom); hint2_address = $urandom; hint2_data = $urandom;
  endtask

  task automatic run_step(input int idx, input vec_t v);
    int k;
    int wr0;
    @(negedge clk); #1;
    drive_vec(v);
    in_valid   = 1'b1;
    done_ready = 1'b0;
    @(negedge clk); #1;  // accept edge passed
    wr0      = wr_total;
    in_valid = 1'b0;
    scramble();
    k = 0;
    while (!done_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk($sformatf("v%0d done latency", idx), k, 3);
    chk($sformatf("v%0d fault", idx), {29'd0, fault}, {29'd0, v.exp_fault});
    chk($sformatf("v%0d writes", idx), wr_total - wr0, v.exp_nwr);
    if (idx == 0) begin
      chk("v0 reg sel", {29'd0, last_sel}, {29'd0, REG_EBX});
      chk("v0 reg data", last_data, 32'hDEADBEEF);
    end
    if (idx == 7) chk("v7 last write wins", last_data, 32'h0000000B);
    repeat (v.rdy_dly) @(negedge clk);
    #1;
    done_ready = 1'b1;
    @(negedge clk); #1;
    done_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{OPND_DEST_REG_1HOT, 32'd3, 32'hDEADBEEF, OPND_DEST_NONE, 32'd0, 32'd0,
                1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'b000, 1, 0};
    vecs[1] = '{OPND_DEST_MEM_1HOT, 32'h1000, 32'd5, OPND_DEST_NONE, 32'd0, 32'd0,
                1'b1, 32'h1000, 32'd5, 1'b0, 32'h1000, 32'd5, 3'b000, 0, 2};
    vecs[2] = '{OPND_DEST_MEM_1HOT, 32'h1000, 32'd5, OPND_DEST_NONE, 32'd0, 32'd0,
                1'b1, 32'h1000, 32'd6, 1'b0, 32'd0, 32'd0, 3'b010 | HINTF, 0, 0};
    vecs[3] = '{OPND_DEST_MEM_1HOT, 32'h2000, 32'd7, OPND_DEST_MEM_1HOT, 32'h2000, 32'd7,
                1'b1, 32'h2000, 32'd7, 1'b1, 32'h2000, 32'd7, 3'b000, 0, 1};
    vecs[4] = '{OPND_DEST_MEM_1HOT, 32'h2000, 32'd7, OPND_DEST_MEM_1HOT, 32'h2000, 32'd7,
                1'b1, 32'h2000, 32'd7, 1'b0, 32'h2000, 32'd7, 3'b010, 0, 0};
    vecs[5] = '{2'b11, 32'd0, 32'd0, OPND_DEST_REG_1HOT, 32'h8, 32'd1,
                1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'b001, 0, 0};
    vecs[6] = '{OPND_DEST_REG_1HOT, 32'd2, 32'h11, OPND_DEST_NONE, 32'd0, 32'd0,
                1'b1, 32'h40, 32'd0, 1'b0, 32'd0, 32'd0, HINTF, 1, 0};
    vecs[7] = '{OPND_DEST_REG_1HOT, 32'd5, 32'hA, OPND_DEST_REG_1HOT, 32'd5, 32'hB,
                1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'b000, 2, 3};
    vecs[8] = '{OPND_DEST_MEM_1HOT, 32'h300, 32'd1, 2'b11, 32'd0, 32'd0,
                1'b0, 32'h300, 32'd1, 1'b0, 32'd0, 32'd0, 3'b011, 0, 0};
    vecs[9] = '{OPND_DEST_NONE, 32'd0, 32'd0, OPND_DEST_MEM_1HOT, 32'h44, 32'd9,
                1'b1, 32'h48, 32'd9, 1'b1, 32'h44, 32'd9, HINTF, 0, 1};

    in_valid   = 1'b0;
    done_ready = 1'b0;
    drive_vec(vecs[0]);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset fault", {29'd0, fault}, 32'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_step(i, vecs[i]);

    // Reset in the cycle after an accept, once dest0's write is already out.
    @(negedge clk); #1;
    drive_vec(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid-step write issued", {31'd0, rf_we}, 32'd1);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post-reset done_valid", {31'd0, done_valid}, 32'd0);
      chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    end
    run_step(0, vecs[0]);
    run_step(7, vecs[7]);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    wr_total = 0;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
